bank_select_sequencer: RTL and testbench

// - Upstream driver of the 2-to-4 active-low bank decoder.
// - Accepts bank-access requests over a valid/ready handshake and queues them in a small FIFO.
// - Replays each request as a timed chip-select cycle: Cs, A1, A0 go to the decoder; exactly one bank strobe goes low per access.
// - Guarantees the address is stable whenever Cs is low, so decoder outputs never glitch between banks.

---
 rtl/bank_seq_pkg.sv | 22 ++
 rtl/bank_select_sequencer_fifo.sv | 50 +++++
 rtl/bank_select_sequencer.sv | 142 ++++++++++++++
 tb/tb_bank_select_sequencer.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/bank_seq_pkg.sv
// Shared types and constants for the bank select sequencer.
// Holds the FSM state encoding and a helper for sizing the phase counter.
package bank_seq_pkg;

    localparam int BANK_W = 2;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SETUP   = 2'd1,
        ACTIVE  = 2'd2,
        RECOVER = 2'd3
    } state_t;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return m;
    endfunction

endpackage

// File: rtl/bank_select_sequencer_fifo.sv
// Small synchronous FIFO queueing bank requests ahead of the sequencer.
// Pointers carry one extra wrap bit so full and empty are distinguishable.
import bank_seq_pkg::*;

module sync_fifo #(
    parameter int WIDTH = BANK_W,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_din,
    input  logic             i_pop,
    output logic             o_full,
    output logic             o_empty,
    output logic [WIDTH-1:0] o_dout
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

    logic [AW:0]      r_wr_ptr;
    logic [AW:0]      r_rd_ptr;
    logic [WIDTH-1:0] r_mem [DEPTH];
    logic             w_do_push;
    logic             w_do_pop;

    assign o_empty   = (r_wr_ptr == r_rd_ptr);
    assign o_full    = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                       (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign w_do_push = i_push && !o_full;
    assign w_do_pop  = i_pop && !o_empty;
    assign o_dout    = r_mem[r_rd_ptr[AW-1:0]];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + PTR_ONE;
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + PTR_ONE;
        end
    end

    // Storage needs no reset: entries are only visible between the pointers.
    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wr_ptr[AW-1:0]] <= i_din;
    end

endmodule

// File: rtl/bank_select_sequencer.sv
// Queues bank requests and replays each as a timed, glitch-free chip-select
// cycle (setup / active / recover) towards a 2-to-4 active-low bank decoder.
import bank_seq_pkg::*;

module bank_select_sequencer #(
    parameter int FIFO_DEPTH     = 4,
    parameter int SETUP_CYCLES   = 1,
    parameter int HOLD_CYCLES    = 2,
    parameter int RECOVER_CYCLES = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    input  logic [BANK_W-1:0] req_bank,
    output logic              req_ready,
    output logic              Cs,
    output logic              A1,
    output logic              A0,
    output logic              busy,
    output logic              done
);

    localparam int MAXC = max3(SETUP_CYCLES, HOLD_CYCLES, RECOVER_CYCLES);
    localparam int CW   = $clog2(MAXC + 1);

    localparam logic [CW-1:0] C_SETUP   = CW'(SETUP_CYCLES);
    localparam logic [CW-1:0] C_HOLD    = CW'(HOLD_CYCLES);
    localparam logic [CW-1:0] C_RECOVER = CW'(RECOVER_CYCLES);
    localparam logic [CW-1:0] C_ONE     = CW'(1);

    state_t              r_state;
    state_t              w_next_state;
    logic [CW-1:0]       r_cnt;
    logic [CW-1:0]       w_cnt_next;
    logic                w_pop;
    logic                w_push;
    logic                w_fifo_full;
    logic                w_fifo_empty;
    logic [BANK_W-1:0]   w_fifo_dout;
    logic [BANK_W-1:0]   r_addr;
    logic                r_cs;
    logic                r_done;

    // Ready depends only on registered FIFO state, so a full FIFO refuses
    // a push even in a cycle where the sequencer pops.
    assign req_ready = !w_fifo_full;
    assign w_push    = req_valid && !w_fifo_full;

    sync_fifo #(
        .WIDTH (BANK_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (w_push),
        .i_din   (req_bank),
        .i_pop   (w_pop),
        .o_full  (w_fifo_full),
        .o_empty (w_fifo_empty),
        .o_dout  (w_fifo_dout)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_next_state;
            r_cnt   <= w_cnt_next;
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_cnt_next   = r_cnt;
        w_pop        = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (!w_fifo_empty) begin
                    w_pop        = 1'b1;
                    w_next_state = SETUP;
                    w_cnt_next   = C_SETUP;
                end
            end
            SETUP: begin
                if (r_cnt == C_ONE) begin
                    w_next_state = ACTIVE;
                    w_cnt_next   = C_HOLD;
                end else begin
                    w_cnt_next = r_cnt - C_ONE;
                end
            end
            ACTIVE: begin
                if (r_cnt == C_ONE) begin
                    w_next_state = RECOVER;
                    w_cnt_next   = C_RECOVER;
                end else begin
                    w_cnt_next = r_cnt - C_ONE;
                end
            end
            RECOVER: begin
                if (r_cnt == C_ONE) begin
                    if (!w_fifo_empty) begin
                        w_pop        = 1'b1;
                        w_next_state = SETUP;
                        w_cnt_next   = C_SETUP;
                    end else begin
                        w_next_state = IDLE;
                        w_cnt_next   = '0;
                    end
                end else begin
                    w_cnt_next = r_cnt - C_ONE;
                end
            end
            default: begin
                w_next_state = IDLE;
                w_cnt_next   = '0;
            end
        endcase
    end

    // Outputs are decoded from the next state so they are registered yet
    // aligned with the state they belong to; the address only loads on a pop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_addr <= '0;
            r_cs   <= 1'b1;
            r_done <= 1'b0;
        end else begin
            if (w_pop) r_addr <= w_fifo_dout;
            r_cs   <= (w_next_state != ACTIVE);
            r_done <= (w_next_state == RECOVER) && (r_state != RECOVER);
        end
    end

    assign Cs   = r_cs;
    assign A1   = r_addr[1];
    assign A0   = r_addr[0];
    assign done = r_done;
    assign busy = (r_state != IDLE) || !w_fifo_empty;

endmodule

// File: tb/tb_bank_select_sequencer.sv
// Scoreboard bench: each accepted request is predicted (bank, Cs-fall edge)
// from the timing rules; a monitor checks every Cs-low window against it.
module tb_bank_select_sequencer;

    localparam int DEPTH  = 4;
    localparam int SETUP  = 1;
    localparam int HOLD   = 2;
    localparam int RECOV  = 1;
    localparam int PERIOD = SETUP + HOLD + RECOV;

    typedef struct {
        int bank;
        int fall;
        int pop;
        int fin;
    } rec_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       req_valid = 1'b0;
    logic [1:0] req_bank = '0;
    logic       req_ready, Cs, A1, A0, busy, done;

    logic       r2_valid = 1'b0;
    logic [1:0] r2_bank = '0;
    logic       r2_ready, cs2, a1_2, a0_2, busy2, done2;

    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    int   last_fall = -100;
    rec_t exp_q[$];
    rec_t inflight[$];

    logic       prev_cs = 1'b1;
    logic [1:0] cur_addr = '0;
    int         low_len = 0;

    bank_select_sequencer #(
        .FIFO_DEPTH(DEPTH), .SETUP_CYCLES(SETUP), .HOLD_CYCLES(HOLD), .RECOVER_CYCLES(RECOV)
    ) dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_bank(req_bank),
        .req_ready(req_ready), .Cs(Cs), .A1(A1), .A0(A0), .busy(busy), .done(done)
    );

    bank_select_sequencer #(
        .FIFO_DEPTH(4), .SETUP_CYCLES(2), .HOLD_CYCLES(3), .RECOVER_CYCLES(1)
    ) dut2 (
        .clk(clk), .rst_n(rst_n), .req_valid(r2_valid), .req_bank(r2_bank),
        .req_ready(r2_ready), .Cs(cs2), .A1(a1_2), .A0(a0_2), .busy(busy2), .done(done2)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at cycle %0d", name, act, exp, cyc);
        end
    endtask

    // One cycle of stimulus; also checks ready/busy against occupancy model.
    task automatic drive(input bit v, input logic [1:0] b, output bit acc);
        int   occ;
        rec_t r;
        @(negedge clk);
        while (inflight.size() > 0 && inflight[0].fin <= cyc) void'(inflight.pop_front());
        occ = 0;
        foreach (inflight[i]) if (inflight[i].pop > cyc) occ++;
        check("req_ready", req_ready, occ < DEPTH);
        check("busy", busy, inflight.size() > 0);
        req_valid = v;
        req_bank  = b;
        #1;
        acc = v && req_ready;
        if (acc) begin
            r.bank = b;
            r.fall = (cyc + 2 + SETUP > last_fall + PERIOD) ? cyc + 2 + SETUP : last_fall + PERIOD;
            r.pop  = r.fall - SETUP;
            r.fin  = r.fall + HOLD + RECOV;
            last_fall = r.fall;
            exp_q.push_back(r);
            inflight.push_back(r);
        end
    endtask

    task automatic idle(input int n);
        bit acc;
        for (int i = 0; i < n; i++) drive(1'b0, 2'd0, acc);
    endtask

    task automatic send(input logic [1:0] b);
        bit acc;
        int n;
        acc = 1'b0;
        n = 0;
        while (!acc && n < 50) begin
            drive(1'b1, b, acc);
            n++;
        end
        if (!acc) check("send_timeout", 0, 1);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((exp_q.size() > 0 || inflight.size() > 0) && n < 100) begin
            idle(1);
            n++;
        end
        if (n >= 100) check("drain_timeout", 0, 1);
    endtask

    always @(negedge clk) begin
        rec_t r;
        if (!rst_n) begin
            prev_cs = 1'b1;
            low_len = 0;
        end else begin
            if (Cs === 1'b0 && prev_cs === 1'b1) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_access", 1, 0);
                end else begin
                    r = exp_q.pop_front();
                    check("bank", {A1, A0}, r.bank);
                    check("fall_edge", cyc, r.fall);
                end
                cur_addr = {A1, A0};
                low_len  = 1;
            end else if (Cs === 1'b0) begin
                check("addr_stable", {A1, A0}, cur_addr);
                low_len++;
            end else if (prev_cs === 1'b0) begin
                check("cs_low_len", low_len, HOLD);
            end
            check("done", done, (prev_cs === 1'b0) && (Cs === 1'b1));
            prev_cs = Cs;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        bit acc;
        int n;
        repeat (2) @(negedge clk);
        check("rst_cs", Cs, 1);
        check("rst_addr", {A1, A0}, 0);
        check("rst_done", done, 0);
        check("rst_busy", busy, 0);
        check("rst_ready", req_ready, 1);
        #1 rst_n = 1'b1;

        // Single request, then drain back to idle.
        send(2'd2);
        idle(10);
        check("idle_addr_kept", {A1, A0}, 2);

        // Back-to-back burst hitting every bank in order.
        for (int i = 0; i < 4; i++) send(2'(i));
        drain();

        // Six requests with valid held high; exercises full FIFO and push during pop.
        for (int i = 0; i < 6; i++) send(2'($urandom_range(0, 3)));
        drain();

        // Random traffic.
        for (int i = 0; i < 300; i++)
            drive($urandom_range(0, 2) != 0, 2'($urandom_range(0, 3)), acc);
        drain();

        // Reset in the middle of an active window.
        send(2'd2);
        send(2'd3);
        n = 0;
        while (Cs !== 1'b0 && n < 20) begin
            idle(1);
            n++;
        end
        check("reach_active", Cs, 0);
        #2 rst_n = 1'b0;
        #1;
        check("midrst_cs", Cs, 1);
        check("midrst_done", done, 0);
        check("midrst_busy", busy, 0);
        check("midrst_ready", req_ready, 1);
        exp_q.delete();
        inflight.delete();
        last_fall = -100;
        @(negedge clk);
        #1 rst_n = 1'b1;
        send(2'd1);
        drain();

        // Non-default timing: SETUP=2, HOLD=3, RECOVER=1.
        @(negedge clk);
        r2_bank  = 2'd3;
        r2_valid = 1'b1;
        @(negedge clk);
        r2_valid = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            check("p2_cs", cs2, !(k >= 3 && k <= 5));
            check("p2_done", done2, k == 6);
            if (k == 1) check("p2_addr", {a1_2, a0_2}, 3);
            if (k >= 7) check("p2_busy", busy2, 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
